// File: rtl/mem_req_queue_pkg.sv
// Shared memory-controller types: request entry layout, address split and a saturating counter helper.
// Used by mem_req_queue, mem_req_fifo and mem_req_queue_if.
package mem_ctrlr_pkg;

    localparam int BANK_W = 2;
    localparam int ROW_W  = 12;
    localparam int COL_W  = 8;
    localparam int ADDR_W = 22;
    localparam int DATA_W = 16;

    typedef struct packed {
        logic              write;
        logic [BANK_W-1:0] bank;
        logic [ROW_W-1:0]  row;
        logic [COL_W-1:0]  col;
        logic [DATA_W-1:0] data;
    } mem_req_t;

    typedef struct packed {
        logic [BANK_W-1:0] bank;
        logic [ROW_W-1:0]  row;
        logic [COL_W-1:0]  col;
    } addr_fields_t;

    // Word address layout is {bank, row, col}, bank in the top bits.
    function automatic addr_fields_t split_addr(input logic [ADDR_W-1:0] addr);
        addr_fields_t f;
        f.bank = addr[ADDR_W-1 -: BANK_W];
        f.row  = addr[COL_W +: ROW_W];
        f.col  = addr[COL_W-1:0];
        return f;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic en);
        return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
    endfunction

endpackage

// File: rtl/mem_req_queue_if.sv
// Host request / SDRAM command bundle for mem_req_queue.
// Optional statistics outputs exist only when MEM_REQ_QUEUE_STATS_EN is defined.
interface mem_req_queue_if #(parameter int DEPTH = 8);
    import mem_ctrlr_pkg::*;

    logic                    we;
    logic                    re;
    logic [ADDR_W-1:0]       addr;
    logic [DATA_W-1:0]       data_in;
    logic                    ready;
    logic                    proto_err;
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic                    cmd_write;
    logic [BANK_W-1:0]       cmd_bank;
    logic [ROW_W-1:0]        cmd_row;
    logic [COL_W-1:0]        cmd_col;
    logic [DATA_W-1:0]       cmd_data;
    logic                    cmd_row_hit;
    logic                    close_all;
    logic [$clog2(DEPTH):0]  count;
`ifdef MEM_REQ_QUEUE_STATS_EN
    logic [15:0]             stat_reads;
    logic [15:0]             stat_writes;
    logic [15:0]             stat_hits;
    logic [15:0]             stat_full;

    modport slave (
        input  we, re, addr, data_in, cmd_ready, close_all,
        output ready, proto_err, cmd_valid, cmd_write, cmd_bank, cmd_row, cmd_col,
               cmd_data, cmd_row_hit, count,
               stat_reads, stat_writes, stat_hits, stat_full
    );
    modport master (
        output we, re, addr, data_in, cmd_ready, close_all,
        input  ready, proto_err, cmd_valid, cmd_write, cmd_bank, cmd_row, cmd_col,
               cmd_data, cmd_row_hit, count,
               stat_reads, stat_writes, stat_hits, stat_full
    );
`else
    modport slave (
        input  we, re, addr, data_in, cmd_ready, close_all,
        output ready, proto_err, cmd_valid, cmd_write, cmd_bank, cmd_row, cmd_col,
               cmd_data, cmd_row_hit, count
    );
    modport master (
        output we, re, addr, data_in, cmd_ready, close_all,
        input  ready, proto_err, cmd_valid, cmd_write, cmd_bank, cmd_row, cmd_col,
               cmd_data, cmd_row_hit, count
    );
`endif

endinterface

// File: rtl/mem_req_fifo.sv
// Show-ahead FIFO of mem_req_t with explicit occupancy count.
// Caller guarantees no push when full and no pop when empty.
module mem_req_fifo
    import mem_ctrlr_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push_i,
    input  mem_req_t         din_i,
    input  logic             pop_i,
    output mem_req_t         dout_o,
    output logic [CNT_W-1:0] count_o
);

    mem_req_t         mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        wr_ptr_d = push_i ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_i  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage deliberately has no reset; only the pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/mem_req_queue.sv
// Host request queue in front of the SDRAM command core: FIFO, address split, open-row hint, protocol error flag.
// Define MEM_REQ_QUEUE_STATS_EN to add saturating read/write/hit/full statistics counters.
module mem_req_queue
    import mem_ctrlr_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    mem_req_queue_if.slave    bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int NBANK = 1 << BANK_W;

    addr_fields_t     fields;
    mem_req_t         enq_entry;
    mem_req_t         head;
    logic [CNT_W-1:0] count;
    logic             ready;
    logic             cmd_valid;
    logic             push;
    logic             pop;
    logic             row_hit;
    logic             proto_err_q;
    logic [NBANK-1:0] row_vld_q;
    logic [ROW_W-1:0] row_tag_q [NBANK];

    always_comb begin
        fields    = split_addr(bus.addr);
        enq_entry = '{write: bus.we, bank: fields.bank, row: fields.row,
                      col: fields.col, data: bus.data_in};
    end

    assign ready     = (count != CNT_W'(DEPTH));
    assign cmd_valid = (count != '0);
    assign push      = (bus.we ^ bus.re) && ready;
    assign pop       = cmd_valid && bus.cmd_ready;

    mem_req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (clock),
        .rst_n_i (reset_n),
        .push_i  (push),
        .din_i   (enq_entry),
        .pop_i   (pop),
        .dout_o  (head),
        .count_o (count)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            proto_err_q <= 1'b0;
        end else if (bus.we && bus.re) begin
            proto_err_q <= 1'b1;
        end
    end

    // close_all outranks a same-cycle dequeue so the bank just touched stays closed.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            row_vld_q <= '0;
        end else if (bus.close_all) begin
            row_vld_q <= '0;
        end else if (pop) begin
            row_vld_q[head.bank] <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (pop) begin
            row_tag_q[head.bank] <= head.row;
        end
    end

    assign row_hit = cmd_valid && row_vld_q[head.bank] && (row_tag_q[head.bank] == head.row);

    assign bus.ready       = ready;
    assign bus.proto_err   = proto_err_q;
    assign bus.cmd_valid   = cmd_valid;
    assign bus.cmd_write   = head.write;
    assign bus.cmd_bank    = head.bank;
    assign bus.cmd_row     = head.row;
    assign bus.cmd_col     = head.col;
    assign bus.cmd_data    = head.data;
    assign bus.cmd_row_hit = row_hit;
    assign bus.count       = count;

`ifdef MEM_REQ_QUEUE_STATS_EN
    logic [15:0] stat_reads_q;
    logic [15:0] stat_writes_q;
    logic [15:0] stat_hits_q;
    logic [15:0] stat_full_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            stat_reads_q  <= '0;
            stat_writes_q <= '0;
            stat_hits_q   <= '0;
            stat_full_q   <= '0;
        end else begin
            stat_reads_q  <= sat_inc16(stat_reads_q,  pop && !head.write);
            stat_writes_q <= sat_inc16(stat_writes_q, pop && head.write);
            stat_hits_q   <= sat_inc16(stat_hits_q,   pop && row_hit);
            stat_full_q   <= sat_inc16(stat_full_q,   (bus.we || bus.re) && !ready);
        end
    end

    assign bus.stat_reads  = stat_reads_q;
    assign bus.stat_writes = stat_writes_q;
    assign bus.stat_hits   = stat_hits_q;
    assign bus.stat_full   = stat_full_q;
`endif

endmodule

// File: doc/mem_req_queue.md
Name: mem_req_queue

Overview:
- Front-end stage between the hardware testbench request interface (we/re/addr/data_in/ready) and the SDRAM command core of the memory controller.
- Buffers host requests in a FIFO and splits the 22-bit word address into bank/row/column fields.
- Tags each dequeued request with a per-bank open-row hit hint, so the core can skip ACTIVATE/PRECHARGE.

Parameters:
- DEPTH, 8, FIFO entries; power of 2, minimum 2.
- ROW_W, 12, row address bits.
- COL_W, 8, column address bits (BANK_W fixed at 2; ROW_W+COL_W+2 = 22).

Ports:
- clock  input  1  system clock (133 MHz domain)
- reset_n  input  1  synchronous active-low reset
- we  input  1  host write request, one-cycle pulse
- re  input  1  host read request, one-cycle pulse
- addr  input  22  host word address
- data_in  input  16  host write data
- ready  output  1  queue can accept a request this cycle
- proto_err  output  1  sticky: we and re both asserted in one cycle
- cmd_valid  output  1  head entry valid
- cmd_ready  input  1  core accepts head entry
- cmd_write  output  1  1 = write, 0 = read
- cmd_bank  output  2  addr[21:20]
- cmd_row  output  ROW_W  addr[19:8]
- cmd_col  output  COL_W  addr[7:0]
- cmd_data  output  16  write data (don't-care on reads)
- cmd_row_hit  output  1  head's row is currently open in its bank
- close_all  input  1  core issued PRECHARGE ALL / REFRESH; invalidate all open rows
- count  output  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (reset_n sampled low at posedge):
  - wr_ptr = rd_ptr = count = 0; ready = 1; cmd_valid = 0; proto_err = 0.
  - All open-row valid bits cleared; stats counters (if built) = 0.
  - Reset mid-operation discards all queued entries. FIFO storage itself is not reset.
- Enqueue: fires on (we ^ re) && ready.
  - Stores {we, addr, data_in}; the entry becomes visible at the head on the next cycle (latency 1). No bypass path.
- ready = (count != DEPTH), combinational from registered count.
  - we/re while ready = 0: request dropped; queue state unchanged; host must not do this.
- we && re in the same cycle:
  - Nothing is enqueued; proto_err sets and stays set until reset.
- Dequeue: fires on cmd_valid && cmd_ready.
  - cmd_* are driven from the head entry (show-ahead).
  - cmd_valid = (count != 0).
  - cmd_* stay stable while cmd_valid && !cmd_ready.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance.
  - Full: enqueue is blocked by ready = 0 even if a dequeue fires the same cycle.
  - Empty: the new entry is not visible until the next cycle.
- Pointers are $clog2(DEPTH) bits, wrap naturally; count is tracked separately to distinguish full from empty.
- Open-row table: 4 entries of {valid, row}.
  - cmd_row_hit = table[cmd_bank].valid && table[cmd_bank].row == cmd_row && cmd_valid.
  - On dequeue: table[cmd_bank] <= {1, cmd_row}.
  - On close_all: all valid bits cleared. If a dequeue fires in the same cycle, close_all wins: the dequeued bank's entry is also left invalid.
- No FSM beyond the FIFO control; two states are implied (EMPTY when count = 0, ACTIVE otherwise). Transitions follow count.

Optional Feature:
- Macro: MEM_REQ_QUEUE_STATS_EN.
- When defined, adds outputs:
  - stat_reads [15:0] and stat_writes [15:0]: increment on each dequeue of that type, saturating at 16'hFFFF.
  - stat_hits [15:0]: increments on dequeue with cmd_row_hit = 1, saturating.
  - stat_full [15:0]: increments on each cycle with we|re asserted while ready = 0, saturating.
- All counters reset to 0.
- When undefined: these ports and their logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package mem_ctrlr_pkg holds:
  - constants BANK_W = 2, ROW_W = 12, COL_W = 8, ADDR_W = 22, DATA_W = 16;
  - typedef struct packed mem_req_t {write, bank, row, col, data};
  - function split_addr(addr) returning {bank, row, col}.
- One sub-module: mem_req_fifo (generic show-ahead FIFO of mem_req_t with count).
  - mem_req_queue wraps it and adds address split, the open-row table, proto_err and stats.

Test Plan:
- Reset then idle -> ready = 1, cmd_valid = 0, count = 0, proto_err = 0.
- we, addr = 22'h2ABCDE, data_in = 16'hBEEF, cmd_ready = 0 -> next cycle:
  - cmd_valid = 1, cmd_write = 1, cmd_bank = 2, cmd_row = 12'hABC, cmd_col = 8'hDE, cmd_data = 16'hBEEF;
  - cmd_row_hit = 0.
- 8 back-to-back re with cmd_ready = 0 -> count = 8, ready = 0; a 9th re is dropped and count stays 8. Then cmd_ready = 1 -> entries emerge in order at one per cycle, and cmd_valid = 0 after the 8th.
- Dequeue read 22'h100010, then read 22'h100020 -> second has cmd_row_hit = 1. Pulse close_all between them -> second has cmd_row_hit = 0.
- we = re = 1 for one cycle -> count unchanged, proto_err = 1 and held. reset_n = 0 with 3 entries queued -> count = 0, cmd_valid = 0, proto_err = 0.
- Steady enqueue every cycle with cmd_ready = 1 -> count holds at 1, and pointers wrap past DEPTH without data loss (check 20 sequential addresses).
